// File: rtl/wm_embed_sched.sv
// wm_embed_sched: paces an 8-bit pixel stream into a watermark embedding core.
//
// Each accepted pixel is paired with the next byte of a looping message buffer
// and handed to the core with a one-cycle core_ce_o. Consecutive core_ce_o
// pulses are at least OVERCLOCK clocks apart. The core result is forwarded as a
// one-cycle m_pix_valid_o exactly CORE_LAT enabled clocks after core_ce_o.
//
// Parameters:
//   OVERCLOCK  clocks per core sample (2..255)
//   CORE_LAT   clocks from core_ce_o to a valid core_pixel_out_i (1..8)
//   MSG_AW     message buffer address width (2**MSG_AW bytes)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clk_enable_i             global enable; low freezes all state
//   s_pix_*                  input pixel stream (valid/ready, data, sof)
//   cfg_we_i/addr/wdata      message buffer write port (IDLE only)
//   cfg_len_i, cfg_arm_i     message length and start request
//   cfg_stop_i               stop after the current sample
//   busy_o                   scheduler not idle
//   core_ce_o/pixel/message  drive to the watermarking core
//   core_pixel_out_i         result from the core
//   m_pix_*                  output pixel stream (no backpressure)
//   stat_frames_o/pixels_o   sample statistics
//
// Optional feature: define WM_SCHED_STATS_EN to build the frame/pixel counters;
// otherwise the statistics outputs are tied to zero.

module wm_embed_sched #(
  parameter int unsigned OVERCLOCK = 5,
  parameter int unsigned CORE_LAT  = 1,
  parameter int unsigned MSG_AW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clk_enable_i,
  input  logic              s_pix_valid_i,
  input  logic [7:0]        s_pix_data_i,
  input  logic              s_pix_sof_i,
  output logic              s_pix_ready_o,
  input  logic              cfg_we_i,
  input  logic [MSG_AW-1:0] cfg_addr_i,
  input  logic [7:0]        cfg_wdata_i,
  input  logic [MSG_AW:0]   cfg_len_i,
  input  logic              cfg_arm_i,
  input  logic              cfg_stop_i,
  output logic              busy_o,
  output logic              core_ce_o,
  output logic [7:0]        core_pixel_o,
  output logic [7:0]        core_message_o,
  input  logic [7:0]        core_pixel_out_i,
  output logic              m_pix_valid_o,
  output logic [7:0]        m_pix_data_o,
  output logic              m_pix_sof_o,
  output logic [15:0]       stat_frames_o,
  output logic [31:0]       stat_pixels_o
);

  typedef enum logic [1:0] {StIdle, StWaitPix, StIssue, StSpace} state_e;

  localparam int unsigned    Depth     = 1 << MSG_AW;
  localparam logic [MSG_AW:0] MaxLen   = (MSG_AW+1)'(Depth);
  // SPACE counts down from OVERCLOCK-3 to 0, i.e. OVERCLOCK-2 cycles.
  localparam logic [7:0]     SpaceInit = (OVERCLOCK > 2) ? 8'(OVERCLOCK - 3) : 8'd0;

  state_e              state_q, state_d;
  logic [MSG_AW:0]     len_q, len_d;
  logic [MSG_AW-1:0]   idx_q, idx_d;
  logic [7:0]          pix_q, pix_d;
  logic [7:0]          msg_q, msg_d;
  logic                sof_q, sof_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [CORE_LAT-1:0] vld_q, vld_d;
  logic [CORE_LAT-1:0] psof_q, psof_d;
  logic [7:0]          out_q;

  logic [7:0]          msg_mem [Depth];

  logic                accept;
  logic                arm_ok;
  logic                stop_now;
  logic [MSG_AW-1:0]   sel_idx;
  logic                idx_wrap;

  // Ready is withheld while disabled or while a stop is requested so that a
  // handshake never coincides with a frozen or stopping scheduler.
  assign s_pix_ready_o = (state_q == StWaitPix) & clk_enable_i & ~cfg_stop_i;
  assign accept        = s_pix_valid_i & s_pix_ready_o;
  assign arm_ok        = cfg_arm_i && (cfg_len_i != '0) && (cfg_len_i <= MaxLen);
  assign stop_now      = stop_q | cfg_stop_i;
  assign sel_idx       = s_pix_sof_i ? '0 : idx_q;
  assign idx_wrap      = (({1'b0, sel_idx} + (MSG_AW+1)'(1)) == len_q);

  assign busy_o         = (state_q != StIdle);
  assign core_ce_o      = (state_q == StIssue) & clk_enable_i;
  assign core_pixel_o   = pix_q;
  assign core_message_o = msg_q;

  assign m_pix_valid_o = vld_q[CORE_LAT-1] & clk_enable_i;
  assign m_pix_sof_o   = psof_q[CORE_LAT-1] & m_pix_valid_o;
  // Pass the core result through on the pulse, hold the last one otherwise.
  assign m_pix_data_o  = m_pix_valid_o ? core_pixel_out_i : out_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    msg_d   = msg_q;
    sof_d   = sof_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    if (clk_enable_i) begin
      unique case (state_q)
        StIdle: begin
          if (arm_ok) begin
            len_d   = cfg_len_i;
            idx_d   = '0;
            state_d = StWaitPix;
          end
        end
        StWaitPix: begin
          if (cfg_stop_i) begin
            state_d = StIdle;
          end else if (accept) begin
            pix_d   = s_pix_data_i;
            sof_d   = s_pix_sof_i;
            msg_d   = msg_mem[sel_idx];
            idx_d   = idx_wrap ? '0 : sel_idx + MSG_AW'(1);
            stop_d  = 1'b0;
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (OVERCLOCK > 2) begin
            cnt_d   = SpaceInit;
            stop_d  = stop_now;
            state_d = StSpace;
          end else begin
            stop_d  = 1'b0;
            state_d = stop_now ? StIdle : StWaitPix;
          end
        end
        StSpace: begin
          if (cnt_q == 8'd0) begin
            stop_d  = 1'b0;
            state_d = stop_now ? StIdle : StWaitPix;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            stop_d = stop_now;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Latency pipeline keeps running after a stop so in-flight samples drain.
  always_comb begin
    vld_d  = (vld_q << 1) | CORE_LAT'(core_ce_o);
    psof_d = (psof_q << 1) | CORE_LAT'(core_ce_o & sof_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      msg_q   <= '0;
      sof_q   <= 1'b0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      vld_q   <= '0;
      psof_q  <= '0;
      out_q   <= '0;
    end else if (clk_enable_i) begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      msg_q   <= msg_d;
      sof_q   <= sof_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      vld_q   <= vld_d;
      psof_q  <= psof_d;
      if (m_pix_valid_o) out_q <= core_pixel_out_i;
    end
  end

  // Buffer contents survive reset; writes only land while idle.
  always_ff @(posedge clk_i) begin
    if (clk_enable_i && (state_q == StIdle) && cfg_we_i) begin
      msg_mem[cfg_addr_i] <= cfg_wdata_i;
    end
  end

`ifdef WM_SCHED_STATS_EN
  logic [15:0] frames_q;
  logic [31:0] pixels_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frames_q <= '0;
      pixels_q <= '0;
    end else if (core_ce_o) begin
      pixels_q <= pixels_q + 32'd1;
      if (sof_q) frames_q <= frames_q + 16'd1;
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_pixels_o = pixels_q;
`else
  assign stat_frames_o = '0;
  assign stat_pixels_o = '0;
`endif

endmodule

// File: tb/tb_wm_embed_sched.sv
// Scoreboard bench for wm_embed_sched with default parameters.
module tb_wm_embed_sched;

  localparam int unsigned CoreLat = 1;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clk_enable_i;
  logic       s_pix_valid_i;
  logic [7:0] s_pix_data_i;
  logic       s_pix_sof_i;
  logic       s_pix_ready_o;
  logic       cfg_we_i;
  logic [7:0] cfg_addr_i;
  logic [7:0] cfg_wdata_i;
  logic [8:0] cfg_len_i;
  logic       cfg_arm_i;
  logic       cfg_stop_i;
  logic       busy_o;
  logic       core_ce_o;
  logic [7:0] core_pixel_o;
  logic [7:0] core_message_o;
  logic [7:0] core_pixel_out_i;
  logic       m_pix_valid_o;
  logic [7:0] m_pix_data_o;
  logic       m_pix_sof_o;
  logic [15:0] stat_frames_o;
  logic [31:0] stat_pixels_o;

  wm_embed_sched #(.OVERCLOCK(5), .CORE_LAT(CoreLat), .MSG_AW(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clk_enable_i     (clk_enable_i),
    .s_pix_valid_i    (s_pix_valid_i),
    .s_pix_data_i     (s_pix_data_i),
    .s_pix_sof_i      (s_pix_sof_i),
    .s_pix_ready_o    (s_pix_ready_o),
    .cfg_we_i         (cfg_we_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_wdata_i      (cfg_wdata_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_arm_i        (cfg_arm_i),
    .cfg_stop_i       (cfg_stop_i),
    .busy_o           (busy_o),
    .core_ce_o        (core_ce_o),
    .core_pixel_o     (core_pixel_o),
    .core_message_o   (core_message_o),
    .core_pixel_out_i (core_pixel_out_i),
    .m_pix_valid_o    (m_pix_valid_o),
    .m_pix_data_o     (m_pix_data_o),
    .m_pix_sof_o      (m_pix_sof_o),
    .stat_frames_o    (stat_frames_o),
    .stat_pixels_o    (stat_pixels_o)
  );

  always #5 clk_i = ~clk_i;

  // Core model: one-cycle latency, output = pixel XOR message byte.
  always @(posedge clk_i) if (core_ce_o) core_pixel_out_i <= core_pixel_o ^ core_message_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = 0;
  int last_ce = -1;
  int exp_gap = 0;

  logic [15:0] ce_q[$];   // {message, pixel} expected at core_ce
  logic [8:0]  exp_q[$];  // {sof, data} expected at m_pix_valid
  int          lat_q[$];  // enabled-cycle stamp of each core_ce

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    cyc++;
    if (clk_enable_i) en_cyc++;
  end

  always @(negedge clk_i) begin
    logic [15:0] e;
    logic [8:0]  x;
    int          l;
    if (core_ce_o) begin
      checks++;
      if (ce_q.size() == 0) begin
        errors++;
        $display("FAIL ce_unexpected: got core_ce=1 expected no issue at t=%0t", $time);
      end else begin
        e = ce_q.pop_front();
        chk("core_message", 32'(core_message_o), 32'(e[15:8]));
        chk("core_pixel", 32'(core_pixel_o), 32'(e[7:0]));
        if (exp_gap != 0 && last_ce >= 0) chk("ce_gap", 32'(cyc - last_ce), 32'(exp_gap));
        lat_q.push_back(en_cyc);
      end
      last_ce = cyc;
    end
    if (m_pix_valid_o) begin
      checks++;
      if (exp_q.size() == 0 || lat_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got m_pix_valid=1 expected none at t=%0t", $time);
      end else begin
        x = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("m_pix_data", 32'(m_pix_data_o), 32'(x[7:0]));
        chk("m_pix_sof", 32'(m_pix_sof_o), 32'(x[8]));
        chk("out_latency", 32'(en_cyc - l), CoreLat);
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic arm(input logic [8:0] len);
    cfg_len_i = len; cfg_arm_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_arm_i = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_stop_i = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. with the DUT in ISSUE.
  task automatic send_pix(input logic [7:0] d, input logic sof, input logic [7:0] m,
                          input bit track);
    int n = 0;
    s_pix_valid_i = 1'b1; s_pix_data_i = d; s_pix_sof_i = sof;
    if (track) begin
      ce_q.push_back({m, d});
      exp_q.push_back({sof, d ^ m});
    end
    while (!s_pix_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("pix_ready", 32'(s_pix_ready_o), 32'd1);
    @(posedge clk_i); #1;
    s_pix_valid_i = 1'b0; s_pix_sof_i = 1'b0;
  endtask

  logic [7:0] msg_tab [3];
  logic [7:0] exp2 [7];
  logic [15:0] exp_frames;
  logic [31:0] exp_pixels;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    msg_tab[0] = 8'h11; msg_tab[1] = 8'h22; msg_tab[2] = 8'h33;
    exp2[0] = 8'h11; exp2[1] = 8'h22; exp2[2] = 8'h33; exp2[3] = 8'h11;
    exp2[4] = 8'h11; exp2[5] = 8'h22; exp2[6] = 8'h33;
`ifdef WM_SCHED_STATS_EN
    exp_frames = 16'd2; exp_pixels = 32'd18;
`else
    exp_frames = 16'd0; exp_pixels = 32'd0;
`endif
    rst_ni = 1'b0; clk_enable_i = 1'b1; s_pix_valid_i = 1'b0; s_pix_data_i = '0;
    s_pix_sof_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    cfg_len_i = '0; cfg_arm_i = 1'b0; cfg_stop_i = 1'b0;

    // Reset values
    @(negedge clk_i);
    chk("rst_ready", 32'(s_pix_ready_o), 0);
    chk("rst_ce", 32'(core_ce_o), 0);
    chk("rst_mvalid", 32'(m_pix_valid_o), 0);
    chk("rst_msof", 32'(m_pix_sof_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_core_pixel", 32'(core_pixel_o), 0);
    chk("rst_core_message", 32'(core_message_o), 0);
    chk("rst_mdata", 32'(m_pix_data_o), 0);
    chk("rst_frames", 32'(stat_frames_o), 0);
    chk("rst_pixels", stat_pixels_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 3; i++) wr(8'(i), msg_tab[i]);
    arm(9'd3);
    chk("armed_busy", 32'(busy_o), 1);
    chk("armed_ready", 32'(s_pix_ready_o), 1);

    // Stream 1: seven back-to-back pixels, message loops 11,22,33
    exp_gap = 5;
    for (int i = 0; i < 7; i++) send_pix(8'hA0 + 8'(i), 1'b0, msg_tab[i % 3], 1'b1);
    // Stream 2: sof on pixels 1 and 5 restarts the message
    for (int i = 0; i < 7; i++) send_pix(8'hC0 + 8'(i), (i == 0 || i == 4), exp2[i], 1'b1);

    // Pixel A, then freeze three clocks during SPACE
    send_pix(8'h5C, 1'b0, 8'h11, 1'b1);
    @(posedge clk_i); #1;
    clk_enable_i = 1'b0; exp_gap = 8;
    for (int i = 0; i < 3; i++) begin
      chk("frz_core_pixel", 32'(core_pixel_o), 32'h5C);
      chk("frz_core_message", 32'(core_message_o), 32'h11);
      chk("frz_ce", 32'(core_ce_o), 0);
      chk("frz_busy", 32'(busy_o), 1);
      @(posedge clk_i); #1;
    end
    clk_enable_i = 1'b1;
    send_pix(8'h3D, 1'b0, 8'h22, 1'b1);
    @(posedge clk_i); #1;
    exp_gap = 5;

    // Pixel C, stop pulsed in SPACE along with a write attempt
    send_pix(8'h77, 1'b0, 8'h33, 1'b1);
    @(posedge clk_i); #1;
    exp_gap = 0;
    cfg_stop_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 8'h00; cfg_wdata_i = 8'hEE;
    @(posedge clk_i); #1;
    cfg_stop_i = 1'b0; cfg_we_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("stop_busy", 32'(busy_o), 0);
    chk("stop_ready", 32'(s_pix_ready_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("stop_drained", 32'(exp_q.size()), 0);

    // Buffer must still hold 0x11 at address 0
    arm(9'd1);
    send_pix(8'h5A, 1'b0, 8'h11, 1'b1);
    n = 0;
    while (!s_pix_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    pulse_stop();
    chk("waitpix_stop_busy", 32'(busy_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("frames", 32'(stat_frames_o), 32'(exp_frames));
    chk("pixels", stat_pixels_o, exp_pixels);

    // Length boundaries
    arm(9'd0);
    chk("len0_busy", 32'(busy_o), 0);
    arm(9'd257);
    chk("len257_busy", 32'(busy_o), 0);
    arm(9'd256);
    chk("len256_busy", 32'(busy_o), 1);
    pulse_stop();
    chk("len256_stop_busy", 32'(busy_o), 0);

    // Reset in the middle of ISSUE discards the sample
    arm(9'd3);
    send_pix(8'h99, 1'b0, 8'h11, 1'b0);
    chk("issue_ce", 32'(core_ce_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(core_ce_o), 0);
    chk("mid_rst_mvalid", 32'(m_pix_valid_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_core_pixel", 32'(core_pixel_o), 0);
    chk("mid_rst_pixels", stat_pixels_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    chk("end_ce_q", 32'(ce_q.size()), 0);
    chk("end_exp_q", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_embed_sched.md
WM_EMBED_SCHED -- requirements
Module: wm_embed_sched

Interface
REQ-001 The block SHALL have parameter OVERCLOCK, default 5, meaning clocks per core sample (legal 2..255).
REQ-002 The block SHALL have parameter CORE_LAT, default 1, meaning clocks from core_ce to valid core_pixel_out (legal 1..8).
REQ-003 The block SHALL have parameter MSG_AW, default 8, meaning the message buffer address width (depth 2**MSG_AW bytes).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  global enable; low freezes all state.
- s_pix_valid  in  1  input pixel valid.
- s_pix_data  in  8  input pixel.
- s_pix_sof  in  1  input pixel is first of a frame.
- s_pix_ready  out  1  pixel accepted when valid&ready.
- cfg_we  in  1  message buffer write strobe.
- cfg_addr  in  MSG_AW  write address.
- cfg_wdata  in  8  write data.
- cfg_len  in  MSG_AW+1  message length in bytes (1..2**MSG_AW).
- cfg_arm  in  1  start scheduling.
- cfg_stop  in  1  stop after current sample.
- busy  out  1  FSM not IDLE.
- core_ce  out  1  one-cycle enable to the watermarker core.
- core_pixel  out  8  pixel to core.
- core_message  out  8  message byte to core.
- core_pixel_out  in  8  watermarked pixel from core.
- m_pix_valid  out  1  output pixel valid pulse (no backpressure).
- m_pix_data  out  8  output pixel.
- m_pix_sof  out  1  output pixel is first of a frame.
- stat_frames  out  16  frame counter (see Configuration).
- stat_pixels  out  32  pixel counter (see Configuration).

Function
REQ-005 The FSM SHALL have states IDLE, WAIT_PIX, ISSUE and SPACE; when clk_enable=0 no state, counter or output register SHALL change and core_ce SHALL be 0.
REQ-006 In IDLE, cfg_we=1 SHALL write cfg_wdata to buffer[cfg_addr]; cfg_we SHALL be ignored in every other state.
REQ-007 In IDLE, cfg_arm=1 with cfg_len in 1..2**MSG_AW SHALL latch cfg_len, clear the message index and enter WAIT_PIX; an out-of-range cfg_len SHALL keep the FSM in IDLE.
REQ-008 s_pix_ready SHALL be 1 only in WAIT_PIX; on s_pix_valid&s_pix_ready the block SHALL register the pixel, sof and buffer[idx] (idx=0 if sof) and enter ISSUE.
REQ-009 In ISSUE, core_ce SHALL be 1 for exactly one clock with core_pixel/core_message stable, then SPACE SHALL last OVERCLOCK-2 clocks (zero for OVERCLOCK=2), giving a core_ce interval of at least OVERCLOCK clocks.
REQ-010 core_pixel and core_message SHALL hold their values until the next ISSUE.
REQ-011 The message index SHALL advance by one per accepted pixel and wrap from latched_len-1 to 0; s_pix_sof=1 SHALL force index 0 for that pixel.
REQ-012 m_pix_valid SHALL pulse exactly CORE_LAT enabled clocks after each core_ce, with m_pix_data=core_pixel_out and m_pix_sof the sof of that sample.
REQ-013 At the end of SPACE (or ISSUE if OVERCLOCK=2) the FSM SHALL enter IDLE if cfg_stop was seen since the last ISSUE, else WAIT_PIX; cfg_stop in WAIT_PIX SHALL enter IDLE immediately.
REQ-014 Outputs already in the CORE_LAT pipeline SHALL still be delivered after a stop.
REQ-015 busy SHALL be 1 in every state except IDLE.

Reset
REQ-016 While reset=0 the FSM SHALL be IDLE and s_pix_ready, core_ce, m_pix_valid, m_pix_sof, busy SHALL be 0; core_pixel, core_message, m_pix_data, stat_frames and stat_pixels SHALL be 0.
REQ-017 Reset mid-operation SHALL discard in-flight samples; buffer contents need not be cleared.

Configuration
REQ-018 With WM_SCHED_STATS_EN defined, stat_pixels SHALL increment on each core_ce and stat_frames on each core_ce whose sample has sof=1, both wrapping at full scale.
REQ-019 Without WM_SCHED_STATS_EN, the counters SHALL not be built and stat_frames and stat_pixels SHALL be constant 0.

Verification
REQ-020 With buffer {0x11,0x22,0x33}, cfg_len=3 and arm, 7 back-to-back pixels -> core_message 11,22,33,11,22,33,11 and core_ce spaced exactly 5 clocks apart.
REQ-021 With sof asserted on pixel 5 of the above stream -> pixel 5 gets message 0x11, m_pix_sof=1 CORE_LAT clocks after its core_ce, and stat_frames increments (macro on).
REQ-022 With clk_enable=0 for 3 clocks during SPACE -> core_ce spacing becomes 8 clocks and all outputs hold.
REQ-023 With cfg_stop pulsed during SPACE -> one final m_pix_valid, then IDLE, busy=0, s_pix_ready=0; cfg_we while busy leaves the buffer unchanged.
REQ-024 With cfg_len=0 and arm -> stays IDLE; with reset=0 asserted mid-ISSUE -> core_ce and m_pix_valid go 0 at once and no output pulse follows.
